// File: rtl/spy_readout.sv
// rtl/spy_readout.sv - spy buffer reader: header word, then the RAM streamed out in address order
// Read issue is credit-limited against a small FIFO so output backpressure never drops RAM data.
module spy_readout #(
  parameter int                ADDR_W = 11,
  parameter int                DATA_W = 16,
  parameter int                RD_LAT = 2,
  parameter logic [DATA_W-1:0] HEADER = 16'h5A11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_locked,
  input  logic              start,
  output logic              rden,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              rearm,
  output logic              overflow_err
);

  localparam int FIFO_D = RD_LAT + 2;
  localparam int PTR_W  = $clog2(FIFO_D);
  localparam int CNT_W  = $clog2(2 * FIFO_D + 2);
  localparam logic [CNT_W-1:0] FIFO_D_C = CNT_W'(FIFO_D);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_D - 1);

  typedef enum logic [1:0] {IDLE, HDR, READ, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                rden_q, rden_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                all_issued_q, all_issued_d;
  logic [RD_LAT-1:0]   valid_sr_q, valid_sr_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_D];
  logic [DATA_W-1:0]   fifo_mem_d [FIFO_D];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                ovf_q, ovf_d;

  logic                out_xfer, out_free, pop, wr, fifo_full, issue, last_xfer;
  logic [CNT_W-1:0]    inflight, occ;

  // Reads already committed: the one on the RAM port now plus those still in the latency pipe.
  always_comb begin
    inflight = CNT_W'(rden_q);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(valid_sr_q[i]);
    end
  end

  always_comb begin
    out_xfer  = out_valid_q & out_ready;
    out_free  = ~out_valid_q | out_ready;
    pop       = out_free & (fifo_cnt_q != '0);
    wr        = valid_sr_q[RD_LAT-1];
    fifo_full = (fifo_cnt_q == FIFO_D_C);
    // Credit counts the FIFO after this cycle's pop so a full-rate stream keeps issuing.
    occ       = fifo_cnt_q + inflight + CNT_W'(1) - CNT_W'(pop);
    issue     = ((state_q == HDR) || (state_q == READ)) && !all_issued_q && (occ <= FIFO_D_C);
    last_xfer = (state_q == DRAIN) && out_xfer && (fifo_cnt_q == '0) && (inflight == '0);

    state_d      = state_q;
    rden_d       = 1'b0;
    raddr_d      = raddr_q;
    next_addr_d  = next_addr_q;
    all_issued_d = all_issued_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_mem_d   = fifo_mem_q;
    ovf_d        = ovf_q;

    valid_sr_d[0] = rden_q;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_sr_d[i] = valid_sr_q[i-1];
    end

    if (wr) begin
      if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        fifo_mem_d[wr_ptr_q] = rdata;
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
    end

    if (pop) begin
      out_data_d  = fifo_mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
      rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    fifo_cnt_d = fifo_cnt_q + CNT_W'(wr && !fifo_full) - CNT_W'(pop);

    if (issue) begin
      rden_d      = 1'b1;
      raddr_d     = next_addr_q;
      next_addr_d = next_addr_q + ADDR_W'(1);
      if (next_addr_q == '1) begin
        all_issued_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // Address 0 goes out with the accept so the header transfer overlaps the RAM latency.
        if (start && capture_locked) begin
          state_d      = HDR;
          rden_d       = 1'b1;
          raddr_d      = '0;
          next_addr_d  = ADDR_W'(1);
          all_issued_d = 1'b0;
          out_valid_d  = 1'b1;
          out_data_d   = HEADER;
        end
      end
      HDR: begin
        if (out_xfer) begin
          state_d = all_issued_d ? DRAIN : READ;
        end
      end
      READ: begin
        if (all_issued_d) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rden_q       <= 1'b0;
      raddr_q      <= '0;
      next_addr_q  <= '0;
      all_issued_q <= 1'b0;
      valid_sr_q   <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rden_q       <= rden_d;
      raddr_q      <= raddr_d;
      next_addr_q  <= next_addr_d;
      all_issued_q <= all_issued_d;
      valid_sr_q   <= valid_sr_d;
      fifo_mem_q   <= fifo_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rden         = rden_q;
  assign raddr        = raddr_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign busy         = (state_q != IDLE);
  assign rearm        = last_xfer & ~reset;
  assign overflow_err = ovf_q;

endmodule

// File: doc/spy_readout.md
Name: spy_readout

Overview:
- Reader side of the 2048-deep spy capture buffer.
- Once the capture side has filled and locked the buffer, a host start request makes this block read the RAM in address order and stream the words out over a valid/ready interface, preceded by one header word.
- On completion it pulses a re-arm strobe so the capture side can take a new trigger.
- Sits between the spy RAM read port and the register/readout link.

Parameters:
ADDR_W, 11, RAM address width; depth = 2**ADDR_W words
DATA_W, 16, RAM and stream data width
RD_LAT, 2, RAM read latency in cycles (rdata valid RD_LAT cycles after rden), 1..4
HEADER, 16'h5A11, constant first word of every readout

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
capture_locked  in  1  high while the spy buffer holds a complete capture
start  in  1  one-cycle readout request from host
rden  out  1  RAM read enable
raddr  out  ADDR_W  RAM read address
rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after rden
out_data  out  DATA_W  stream word
out_valid  out  1  stream word valid
out_ready  in  1  downstream accept; transfer = out_valid & out_ready
busy  out  1  readout in progress
rearm  out  1  one-cycle pulse after the last data word transfers
overflow_err  out  1  sticky; internal FIFO written while full (must never assert)

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: rden=0, raddr=0, out_valid=0, out_data=0, busy=0, rearm=0, overflow_err=0. State goes to IDLE and FIFO/credit counters clear.
- Reset mid-readout aborts immediately. Words in flight are dropped and no rearm pulse is issued.
- States:
  - IDLE:
    - start=1 and capture_locked=1 -> go to HDR, busy=1.
    - start with capture_locked=0 is ignored.
  - HDR:
    - Present HEADER on out_data with out_valid=1; hold it until transferred, then go to READ.
    - Reads may be issued in HDR; data queues behind the header.
  - READ:
    - Issue rden with raddr = 0,1,...,2**ADDR_W-1, one address per cycle, whenever credit is available.
    - After address 2**ADDR_W-1 is issued, go to DRAIN.
  - DRAIN:
    - No new reads. Wait until every issued word has been transferred.
    - On the cycle the final data word transfers, pulse rearm=1 for exactly 1 cycle, set busy=0 on the next cycle, and go to IDLE.
- start while busy is ignored.
- Flow control:
  - Internal FIFO depth = RD_LAT+2.
  - A read may be issued only if (words in FIFO + reads in flight + 1) ≤ depth, so out_ready=0 stalls never lose data.
  - Returning rdata is written to the FIFO RD_LAT cycles after rden. A write to a full FIFO sets overflow_err (design error).
- Stream:
  - out_data/out_valid are registered from the FIFO head.
  - While out_valid=1 and out_ready=0, out_data must hold stable.
  - With out_ready held at 1, the steady-state rate is one data word per cycle.
  - Latency from start to the first data word valid ≤ RD_LAT+3 cycles when out_ready=1.
- Total transfer per readout is 1 header + 2**ADDR_W data words, in address order, with no duplicates or gaps.
- raddr wraps only via reset or a new readout: it restarts at 0 on each HDR entry and never increments past the last address.
- capture_locked dropping mid-readout has no effect; the readout completes.

Test Plan:
- capture_locked=1, single start pulse, out_ready=1 -> HEADER 16'h5A11, then words from addr 0..2047 with out_data == preloaded RAM pattern (data = addr ^ 16'h3C00). 2049 transfers, rearm pulses once, busy falls.
- Same run with out_ready driven by a 30%-duty random pattern -> identical 2049-word sequence, out_data stable during stalls, overflow_err stays 0.
- start with capture_locked=0 -> no rden, busy=0, out_valid=0 for 100 cycles.
- Second start at data word 500 of a readout -> ignored; still exactly 2049 words and one rearm.
- reset asserted at data word 1000 -> next cycle: out_valid=0, busy=0, rden=0, no rearm. A new start then reads from addr 0 with header first.
- Sweep RD_LAT=1 and RD_LAT=4 with out_ready=1 -> one word per cycle after the first, first data word within RD_LAT+3 cycles of start.
